// File: rtl/manchester_framer.sv
// Frame builder: wraps each escaped payload frame in a preamble and an SFD, with one registered output slot.
// Optional inter-frame gap state is built only when MANCHESTER_FRAMER_GAP_EN is defined.
module manchester_framer #(
   parameter int                    DATA_WIDTH      = 8,
   parameter int                    PREAMBLE_LEN    = 7,
   parameter logic [DATA_WIDTH-1:0] PREAMBLE_SYMBOL = 8'h55,
   parameter logic [DATA_WIDTH-1:0] SFD_SYMBOL      = 8'hD5,
   parameter int                    IFG_LEN         = 12
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] PREAMBLE = 3'd1;
   localparam logic [2:0] SFD      = 3'd2;
   localparam logic [2:0] PAYLOAD  = 3'd3;
`ifdef MANCHESTER_FRAMER_GAP_EN
   localparam logic [2:0] GAP      = 3'd4;
`endif

   localparam int CNT_MAX = (PREAMBLE_LEN > IFG_LEN) ? PREAMBLE_LEN : IFG_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

   logic [2:0]            state_reg, state_next;
   logic [CNT_W-1:0]      pre_cnt_reg, pre_cnt_next;
   logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
   logic                  tvalid_reg, tvalid_next;
   logic                  tlast_reg, tlast_next;
   logic                  slot_free;
   logic                  do_start;
`ifdef MANCHESTER_FRAMER_GAP_EN
   localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 1);
   logic [CNT_W-1:0]      gap_cnt_reg, gap_cnt_next;
`endif

   assign slot_free     = !tvalid_reg || m_axis_tready;
   assign s_axis_tready = (state_reg == PAYLOAD) && slot_free;
   assign busy          = (state_reg != IDLE);
   assign m_axis_tdata  = tdata_reg;
   assign m_axis_tvalid = tvalid_reg;
   assign m_axis_tlast  = tlast_reg;

   always_comb begin
      state_next   = state_reg;
      pre_cnt_next = pre_cnt_reg;
      tdata_next   = tdata_reg;
      tvalid_next  = tvalid_reg;
      tlast_next   = tlast_reg;
      do_start     = 1'b0;
`ifdef MANCHESTER_FRAMER_GAP_EN
      gap_cnt_next = gap_cnt_reg;
`endif
      // A drained slot goes empty unless something below reloads it this cycle.
      if (slot_free)
         tvalid_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (s_axis_tvalid && slot_free)
               do_start = 1'b1;
         end
         PREAMBLE: begin
            if (slot_free) begin
               tdata_next   = PREAMBLE_SYMBOL;
               tvalid_next  = 1'b1;
               tlast_next   = 1'b0;
               pre_cnt_next = pre_cnt_reg + 1'b1;
               if (pre_cnt_reg == PRE_LAST)
                  state_next = SFD;
            end
         end
         SFD: begin
            if (slot_free) begin
               tdata_next  = SFD_SYMBOL;
               tvalid_next = 1'b1;
               tlast_next  = 1'b0;
               state_next  = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (s_axis_tvalid && slot_free) begin
               tdata_next  = s_axis_tdata;
               tvalid_next = 1'b1;
               tlast_next  = s_axis_tlast;
               if (s_axis_tlast) begin
`ifdef MANCHESTER_FRAMER_GAP_EN
                  state_next   = GAP;
                  gap_cnt_next = '0;
`else
                  state_next   = IDLE;
`endif
               end
            end
         end
`ifdef MANCHESTER_FRAMER_GAP_EN
         GAP: begin
            // Gap cycles count only once the last beat has left the slot; the final
            // gap cycle may already load the next preamble so the gap is exactly IFG_LEN.
            if (!tvalid_reg) begin
               if (gap_cnt_reg == IFG_LAST) begin
                  if (s_axis_tvalid)
                     do_start = 1'b1;
                  else
                     state_next = IDLE;
               end else begin
                  gap_cnt_next = gap_cnt_reg + 1'b1;
               end
            end
         end
`endif
         default: state_next = IDLE;
      endcase

      if (do_start) begin
         tdata_next   = PREAMBLE_SYMBOL;
         tvalid_next  = 1'b1;
         tlast_next   = 1'b0;
         pre_cnt_next = CNT_W'(1);
         state_next   = (PREAMBLE_LEN == 1) ? SFD : PREAMBLE;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg   <= IDLE;
         pre_cnt_reg <= '0;
         tdata_reg   <= '0;
         tvalid_reg  <= 1'b0;
         tlast_reg   <= 1'b0;
`ifdef MANCHESTER_FRAMER_GAP_EN
         gap_cnt_reg <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         pre_cnt_reg <= pre_cnt_next;
         tdata_reg   <= tdata_next;
         tvalid_reg  <= tvalid_next;
         tlast_reg   <= tlast_next;
`ifdef MANCHESTER_FRAMER_GAP_EN
         gap_cnt_reg <= gap_cnt_next;
`endif
      end
   end

endmodule

// File: tb/tb_manchester_framer.sv
// Directed bench for manchester_framer: a cycle table for the basic frame plus
// sequences for back-pressure, payload underrun, single-beat, back-to-back and mid-frame reset.
module tb_manchester_framer;

`ifdef MANCHESTER_FRAMER_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic [7:0] s_axis_tdata = '0;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       s_axis_tlast = 1'b0;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b1;
   logic       m_axis_tlast;
   logic       busy;

   always #5 aclk = ~aclk;

   manchester_framer dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy)
   );

   typedef struct {
      logic       s_valid;
      logic [7:0] s_data;
      logic       s_last;
      logic       m_ready;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_last;
      logic       e_s_ready;
      logic       e_busy;
   } vec_t;

   vec_t       vecs[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   logic [7:0] src_d[$];
   logic       src_l[$];
   logic [7:0] exp_d[$];
   logic       exp_l[$];
   logic [7:0] out_d[$];
   logic       out_l[$];
   int         out_c[$];
   bit         vld_hist[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_queues();
      src_d.delete(); src_l.delete();
      exp_d.delete(); exp_l.delete();
   endtask

   task automatic exp_header();
      for (int i = 0; i < 7; i++) begin
         exp_d.push_back(8'h55);
         exp_l.push_back(1'b0);
      end
      exp_d.push_back(8'hD5);
      exp_l.push_back(1'b0);
   endtask

   task automatic src_beat(input logic [7:0] d, input logic l);
      src_d.push_back(d); src_l.push_back(l);
      exp_d.push_back(d); exp_l.push_back(l);
   endtask

   // Drives the source queue and a ready/valid stall pattern for ncyc cycles,
   // recording every beat accepted downstream and checking slot stability under stall.
   task automatic run(input string name, input int ncyc, input int rdy_from, input int rdy_len,
                      input int vld_from, input int vld_len);
      logic [7:0] prev_d;
      logic       prev_l;
      logic       prev_stall;
      out_d.delete(); out_l.delete(); out_c.delete(); vld_hist.delete();
      prev_stall = 1'b0;
      prev_d = '0;
      prev_l = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge aclk);
         m_axis_tready = !(c >= rdy_from && c < rdy_from + rdy_len);
         s_axis_tvalid = (src_d.size() > 0) && !(c >= vld_from && c < vld_from + vld_len);
         s_axis_tdata  = (src_d.size() > 0) ? src_d[0] : 8'h00;
         s_axis_tlast  = (src_l.size() > 0) ? src_l[0] : 1'b0;
         #1;
         if (prev_stall) begin
            check({name, "_hold_valid"}, m_axis_tvalid, 1'b1);
            check({name, "_hold_data"}, m_axis_tdata, prev_d);
            check({name, "_hold_last"}, m_axis_tlast, prev_l);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_d     = m_axis_tdata;
         prev_l     = m_axis_tlast;
         vld_hist.push_back(m_axis_tvalid);
         if (m_axis_tvalid && m_axis_tready) begin
            out_d.push_back(m_axis_tdata);
            out_l.push_back(m_axis_tlast);
            out_c.push_back(c);
            $display("[TB] %s beat %0d: data=0x%02h last=%0b cycle=%0d",
                     name, out_d.size() - 1, m_axis_tdata, m_axis_tlast, c);
         end
         if (s_axis_tvalid && s_axis_tready) begin
            void'(src_d.pop_front());
            void'(src_l.pop_front());
         end
      end
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
   endtask

   task automatic check_frames(input string name);
      int n;
      check({name, "_count"}, out_d.size(), exp_d.size());
      n = (out_d.size() < exp_d.size()) ? out_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_data%0d", name, i), out_d[i], exp_d[i]);
         check($sformatf("%s_last%0d", name, i), out_l[i], exp_l[i]);
      end
   endtask

   function automatic int bubbles();
      int cnt = 0;
      if (out_c.size() < 2) return -1;
      for (int c = out_c[0] + 1; c < out_c[out_c.size() - 1]; c++)
         if (!vld_hist[c]) cnt++;
      return cnt;
   endfunction

   initial begin
      // Cycle table for the 3-beat frame with downstream always ready.
      vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 7; i++)
         vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'hD5, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, GAP_EN});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, GAP_EN});

      // Reset state
      repeat (3) @(negedge aclk);
      check("rst_tvalid", m_axis_tvalid, 1'b0);
      check("rst_tdata", m_axis_tdata, 8'h00);
      check("rst_tlast", m_axis_tlast, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_s_tready", s_axis_tready, 1'b0);
      aresetn = 1'b1;

      foreach (vecs[i]) begin
         @(negedge aclk);
         s_axis_tvalid = vecs[i].s_valid;
         s_axis_tdata  = vecs[i].s_data;
         s_axis_tlast  = vecs[i].s_last;
         m_axis_tready = vecs[i].m_ready;
         #1;
         check($sformatf("tbl%0d_valid", i), m_axis_tvalid, vecs[i].e_valid);
         check($sformatf("tbl%0d_s_ready", i), s_axis_tready, vecs[i].e_s_ready);
         check($sformatf("tbl%0d_busy", i), busy, vecs[i].e_busy);
         if (vecs[i].e_valid) begin
            check($sformatf("tbl%0d_data", i), m_axis_tdata, vecs[i].e_data);
            check($sformatf("tbl%0d_last", i), m_axis_tlast, vecs[i].e_last);
         end
         $display("[TB] table row %0d: valid=%0b data=0x%02h last=%0b", i,
                  m_axis_tvalid, m_axis_tdata, m_axis_tlast);
      end
      s_axis_tvalid = 1'b0;
      repeat (20) @(negedge aclk);

      // Back-pressure on preamble beat 3
      clear_queues();
      exp_header();
      src_beat(8'hA1, 1'b0);
      src_beat(8'hA2, 1'b1);
      run("stall", 50, 3, 5, 1000, 0);
      check_frames("stall");

      // Source underrun mid-payload
      clear_queues();
      exp_header();
      src_beat(8'h11, 1'b0);
      src_beat(8'h22, 1'b0);
      src_beat(8'h33, 1'b0);
      src_beat(8'h44, 1'b1);
      run("underrun", 50, 1000, 0, 10, 4);
      check_frames("underrun");
      check("underrun_bubbles", bubbles(), 4);

      // Single-beat frame, also checks header/payload latency
      clear_queues();
      exp_header();
      src_beat(8'hE5, 1'b1);
      run("single", 40, 1000, 0, 1000, 0);
      check_frames("single");
      if (out_c.size() == 9) begin
         check("single_first_cycle", out_c[0], 1);
         check("single_sfd_cycle", out_c[7], 8);
         check("single_payload_cycle", out_c[8], 9);
      end

      // Back-to-back frames
      clear_queues();
      exp_header();
      src_beat(8'hB1, 1'b1);
      exp_header();
      src_beat(8'hC1, 1'b1);
      run("b2b", 70, 1000, 0, 1000, 0);
      check_frames("b2b");
      if (out_c.size() == 18)
         check("b2b_gap", out_c[9] - out_c[8], GAP_EN ? 13 : 1);

      // Reset pulse while the SFD is pending
      clear_queues();
      @(negedge aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h77;
      s_axis_tlast  = 1'b1;
      m_axis_tready = 1'b1;
      repeat (7) @(negedge aclk);
      #1;
      check("presfd_busy", busy, 1'b1);
      check("presfd_data", m_axis_tdata, 8'h55);
      aresetn = 1'b0;
      #1;
      check("midrst_tvalid", m_axis_tvalid, 1'b0);
      check("midrst_tdata", m_axis_tdata, 8'h00);
      check("midrst_tlast", m_axis_tlast, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_s_tready", s_axis_tready, 1'b0);
      s_axis_tvalid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      exp_header();
      src_beat(8'hE7, 1'b1);
      run("postrst", 40, 1000, 0, 1000, 0);
      check_frames("postrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
